// File: rtl/pe_array_pkg.sv
// Shared types and elaboration-time helpers for the output-stationary PE array.
package pe_array_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_SKEW,
      ST_DRAIN
   } state_t;

   // Bits needed to index 'value' distinct items (minimum 0).
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w++;
      end
      return w;
   endfunction

   // Full-precision width of a signed operand-by-operand product.
   function automatic int macWidth(input int opndWidth);
      return 2 * opndWidth;
   endfunction

endpackage

// File: rtl/pe_os_mac.sv
// One output-stationary processing element: forwards A right and B down through
// one register stage each, and accumulates A*B whenever both operands are valid.
module pe_os_mac
   import pe_array_pkg::*;
#(
   parameter int OPND_BWIDTH = 8,
   parameter int ACC_BWIDTH  = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rstN,
   input  logic                   i_stall,
   input  logic                   i_clr,
   input  logic [OPND_BWIDTH-1:0] i_a,
   input  logic                   i_aVld,
   input  logic [OPND_BWIDTH-1:0] i_b,
   input  logic                   i_bVld,
   output logic [OPND_BWIDTH-1:0] o_a,
   output logic                   o_aVld,
   output logic [OPND_BWIDTH-1:0] o_b,
   output logic                   o_bVld,
   output logic [ACC_BWIDTH-1:0]  o_acc
);

   localparam int PW = macWidth(OPND_BWIDTH);

   logic [OPND_BWIDTH-1:0]        r_a;
   logic [OPND_BWIDTH-1:0]        r_b;
   logic                          r_aVld;
   logic                          r_bVld;
   logic signed [ACC_BWIDTH-1:0]  r_acc;
   logic signed [PW-1:0]          w_prod;
   logic signed [ACC_BWIDTH-1:0]  w_prodExt;

   assign w_prod    = PW'($signed(i_a)) * PW'($signed(i_b));
   assign w_prodExt = ACC_BWIDTH'(w_prod);

   // Operand forwarding and wrapping accumulation; a start clears everything.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_a    <= '0;
         r_b    <= '0;
         r_aVld <= 1'b0;
         r_bVld <= 1'b0;
         r_acc  <= '0;
      end else if (!i_stall) begin
         if (i_clr) begin
            r_a    <= '0;
            r_b    <= '0;
            r_aVld <= 1'b0;
            r_bVld <= 1'b0;
            r_acc  <= '0;
         end else begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_aVld <= i_aVld;
            r_bVld <= i_bVld;
            if (i_aVld && i_bVld) begin
               r_acc <= r_acc + w_prodExt;
            end
         end
      end
   end

   assign o_a    = r_a;
   assign o_b    = r_b;
   assign o_aVld = r_aVld;
   assign o_bVld = r_bVld;
   assign o_acc  = r_acc;

endmodule

// File: rtl/pe_array_os_ctrl.sv
// Output-stationary GEMM tile: input skew, sequencing FSM, ROWS x COLS PE grid
// and a row-multiplexed result port drained over valid/ready.
module pe_array_os_ctrl
   import pe_array_pkg::*;
#(
   parameter int PE_ARRAY_NUM_ROWS = 32,
   parameter int PE_ARRAY_NUM_COLS = 32,
   parameter int OPND_BWIDTH       = 8,
   parameter int ACC_BWIDTH        = 32,
   parameter int K_LEN_BWIDTH      = 16
) (
   input  logic                                      CLK,
   input  logic                                      RSTn,
   input  logic                                      STALL,
   input  logic                                      START_in,
   input  logic [K_LEN_BWIDTH-1:0]                   K_LEN_in,
   input  logic                                      OPND_VALID_in,
   output logic                                      OPND_READY_out,
   input  logic [PE_ARRAY_NUM_ROWS*OPND_BWIDTH-1:0]  OPND1_DATA_in,
   input  logic [PE_ARRAY_NUM_COLS*OPND_BWIDTH-1:0]  OPND2_DATA_in,
   output logic                                      OUT_VALID_out,
   input  logic                                      OUT_READY_in,
   output logic [PE_ARRAY_NUM_COLS*ACC_BWIDTH-1:0]   OUT_DATA_out,
   output logic [clog2(PE_ARRAY_NUM_ROWS)-1:0]       OUT_ROW_out,
   output logic                                      BUSY_out,
   output logic                                      DONE_out
);

   localparam int ROWS     = PE_ARRAY_NUM_ROWS;
   localparam int COLS     = PE_ARRAY_NUM_COLS;
   localparam int OB       = OPND_BWIDTH;
   localparam int AB       = ACC_BWIDTH;
   localparam int KW       = K_LEN_BWIDTH;
   localparam int RW       = clog2(ROWS);
   localparam int SKEW_CYC = ROWS + COLS - 1;
   localparam int SW       = clog2(SKEW_CYC) + 1;

   state_t            r_state;
   logic [KW-1:0]     r_kLen;
   logic [KW-1:0]     r_kCnt;
   logic [SW-1:0]     r_skewCnt;
   logic [RW-1:0]     r_row;
   logic              r_outValid;
   logic              r_done;

   logic              w_accept;
   logic              w_startAcc;

   logic [OB-1:0]     w_aEdge    [ROWS];
   logic              w_aVldEdge [ROWS];
   logic [OB-1:0]     w_bEdge    [COLS];
   logic              w_bVldEdge [COLS];
   logic [OB-1:0]     w_aOut     [ROWS][COLS];
   logic              w_aVldOut  [ROWS][COLS];
   logic [OB-1:0]     w_bOut     [ROWS][COLS];
   logic              w_bVldOut  [ROWS][COLS];
   logic [COLS*AB-1:0] w_accRow  [ROWS];
   logic [ROWS-1:0]   w_unusedA;
   logic [COLS-1:0]   w_unusedB;

   assign w_accept   = (r_state == ST_FEED) && OPND_VALID_in && !STALL;
   assign w_startAcc = (r_state == ST_IDLE) && START_in && !STALL;

   // Sequencing FSM with its k, skew and output-row counters.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state    <= ST_IDLE;
         r_kLen     <= '0;
         r_kCnt     <= '0;
         r_skewCnt  <= '0;
         r_row      <= '0;
         r_outValid <= 1'b0;
         r_done     <= 1'b0;
      end else if (!STALL) begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (START_in) begin
                  r_kLen    <= K_LEN_in;
                  r_kCnt    <= '0;
                  r_skewCnt <= '0;
                  r_row     <= '0;
                  if (K_LEN_in == '0) begin
                     r_state    <= ST_DRAIN;
                     r_outValid <= 1'b1;
                  end else begin
                     r_state <= ST_FEED;
                  end
               end
            end
            ST_FEED: begin
               if (OPND_VALID_in) begin
                  r_kCnt <= r_kCnt + KW'(1);
                  if (r_kCnt == r_kLen - KW'(1)) begin
                     r_state   <= ST_SKEW;
                     r_skewCnt <= '0;
                  end
               end
            end
            ST_SKEW: begin
               if (r_skewCnt == SW'(SKEW_CYC - 1)) begin
                  r_state    <= ST_DRAIN;
                  r_outValid <= 1'b1;
                  r_row      <= '0;
               end else begin
                  r_skewCnt <= r_skewCnt + SW'(1);
               end
            end
            ST_DRAIN: begin
               if (OUT_READY_in) begin
                  if (r_row == RW'(ROWS - 1)) begin
                     r_state    <= ST_IDLE;
                     r_outValid <= 1'b0;
                     r_done     <= 1'b1;
                     r_row      <= '0;
                  end else begin
                     r_row <= r_row + RW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Row r of A enters the grid r cycles late; bubbles travel as valid=0.
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_aSkew
      if (gr == 0) begin : g_direct
         assign w_aEdge[0]    = OPND1_DATA_in[0 +: OB];
         assign w_aVldEdge[0] = w_accept;
      end else begin : g_pipe
         logic [OB-1:0] r_data [gr];
         logic          r_vld  [gr];
         // Delay line of depth gr for row gr operands.
         always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
               for (int i = 0; i < gr; i++) begin
                  r_data[i] <= '0;
                  r_vld[i]  <= 1'b0;
               end
            end else if (!STALL) begin
               r_data[0] <= OPND1_DATA_in[gr*OB +: OB];
               r_vld[0]  <= w_accept;
               for (int i = 1; i < gr; i++) begin
                  r_data[i] <= r_data[i-1];
                  r_vld[i]  <= r_vld[i-1];
               end
            end
         end
         assign w_aEdge[gr]    = r_data[gr-1];
         assign w_aVldEdge[gr] = r_vld[gr-1];
      end
   end

   // Column c of B enters the grid c cycles late; bubbles travel as valid=0.
   for (genvar gc = 0; gc < COLS; gc++) begin : g_bSkew
      if (gc == 0) begin : g_direct
         assign w_bEdge[0]    = OPND2_DATA_in[0 +: OB];
         assign w_bVldEdge[0] = w_accept;
      end else begin : g_pipe
         logic [OB-1:0] r_data [gc];
         logic          r_vld  [gc];
         // Delay line of depth gc for column gc operands.
         always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
               for (int i = 0; i < gc; i++) begin
                  r_data[i] <= '0;
                  r_vld[i]  <= 1'b0;
               end
            end else if (!STALL) begin
               r_data[0] <= OPND2_DATA_in[gc*OB +: OB];
               r_vld[0]  <= w_accept;
               for (int i = 1; i < gc; i++) begin
                  r_data[i] <= r_data[i-1];
                  r_vld[i]  <= r_vld[i-1];
               end
            end
         end
         assign w_bEdge[gc]    = r_data[gc-1];
         assign w_bVldEdge[gc] = r_vld[gc-1];
      end
   end

   // PE grid: A flows right along a row, B flows down a column.
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         logic [OB-1:0] w_aSel;
         logic [OB-1:0] w_bSel;
         logic          w_aVldSel;
         logic          w_bVldSel;
         if (gc == 0) begin : g_aFromSkew
            assign w_aSel    = w_aEdge[gr];
            assign w_aVldSel = w_aVldEdge[gr];
         end else begin : g_aFromLeft
            assign w_aSel    = w_aOut[gr][gc-1];
            assign w_aVldSel = w_aVldOut[gr][gc-1];
         end
         if (gr == 0) begin : g_bFromSkew
            assign w_bSel    = w_bEdge[gc];
            assign w_bVldSel = w_bVldEdge[gc];
         end else begin : g_bFromAbove
            assign w_bSel    = w_bOut[gr-1][gc];
            assign w_bVldSel = w_bVldOut[gr-1][gc];
         end
         pe_os_mac #(
            .OPND_BWIDTH (OB),
            .ACC_BWIDTH  (AB)
         ) u_pe (
            .i_clk  (CLK),
            .i_rstN (RSTn),
            .i_stall(STALL),
            .i_clr  (w_startAcc),
            .i_a    (w_aSel),
            .i_aVld (w_aVldSel),
            .i_b    (w_bSel),
            .i_bVld (w_bVldSel),
            .o_a    (w_aOut[gr][gc]),
            .o_aVld (w_aVldOut[gr][gc]),
            .o_b    (w_bOut[gr][gc]),
            .o_bVld (w_bVldOut[gr][gc]),
            .o_acc  (w_accRow[gr][gc*AB +: AB])
         );
      end
      assign w_unusedA[gr] = ^{w_aOut[gr][COLS-1], w_aVldOut[gr][COLS-1]};
   end

   for (genvar gc = 0; gc < COLS; gc++) begin : g_bSink
      assign w_unusedB[gc] = ^{w_bOut[ROWS-1][gc], w_bVldOut[ROWS-1][gc]};
   end

   assign OPND_READY_out = (r_state == ST_FEED) && !STALL;
   assign OUT_VALID_out  = r_outValid;
   assign OUT_ROW_out    = r_row;
   assign OUT_DATA_out   = w_accRow[r_row];
   assign BUSY_out       = (r_state != ST_IDLE);
   assign DONE_out       = r_done;

endmodule

// File: tb/tb_pe_array_os_ctrl.sv
// Scoreboard bench for the 4x4 output-stationary tile: the stimulus thread
// queues hand-derived result rows, a monitor compares whatever the DUT presents.
module tb_pe_array_os_ctrl;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int OB   = 8;
   localparam int AB   = 32;
   localparam int KW   = 16;

   logic                  CLK = 1'b0;
   logic                  RSTn;
   logic                  STALL;
   logic                  START_in;
   logic [KW-1:0]         K_LEN_in;
   logic                  OPND_VALID_in;
   logic                  OPND_READY_out;
   logic [ROWS*OB-1:0]    OPND1_DATA_in;
   logic [COLS*OB-1:0]    OPND2_DATA_in;
   logic                  OUT_VALID_out;
   logic                  OUT_READY_in;
   logic [COLS*AB-1:0]    OUT_DATA_out;
   logic [1:0]            OUT_ROW_out;
   logic                  BUSY_out;
   logic                  DONE_out;

   typedef struct {
      int                 row;
      logic [COLS*AB-1:0] data;
      bit                 last;
   } expRow_t;

   expRow_t expQ[$];
   int      checks   = 0;
   int      errors   = 0;
   int      cycle    = 0;
   int      startCyc = 0;
   int      doneChk  = 0;
   int      opA [8][ROWS];
   int      opB [8][COLS];

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle <= cycle + 1;

   pe_array_os_ctrl #(
      .PE_ARRAY_NUM_ROWS(ROWS),
      .PE_ARRAY_NUM_COLS(COLS),
      .OPND_BWIDTH      (OB),
      .ACC_BWIDTH       (AB),
      .K_LEN_BWIDTH     (KW)
   ) dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .STALL         (STALL),
      .START_in      (START_in),
      .K_LEN_in      (K_LEN_in),
      .OPND_VALID_in (OPND_VALID_in),
      .OPND_READY_out(OPND_READY_out),
      .OPND1_DATA_in (OPND1_DATA_in),
      .OPND2_DATA_in (OPND2_DATA_in),
      .OUT_VALID_out (OUT_VALID_out),
      .OUT_READY_in  (OUT_READY_in),
      .OUT_DATA_out  (OUT_DATA_out),
      .OUT_ROW_out   (OUT_ROW_out),
      .BUSY_out      (BUSY_out),
      .DONE_out      (DONE_out)
   );

   task automatic checkOutput(input string name, input logic [COLS*AB-1:0] act,
                              input logic [COLS*AB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pushConst(input int value);
      expRow_t e;
      for (int r = 0; r < ROWS; r++) begin
         e.row  = r;
         e.last = (r == ROWS - 1);
         for (int c = 0; c < COLS; c++) e.data[c*AB +: AB] = value;
         expQ.push_back(e);
      end
   endtask

   task automatic pushModel(input int kLen);
      expRow_t e;
      for (int r = 0; r < ROWS; r++) begin
         e.row  = r;
         e.last = (r == ROWS - 1);
         for (int c = 0; c < COLS; c++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < kLen; k++) sum += opA[k][r] * opB[k][c];
            e.data[c*AB +: AB] = sum;
         end
         expQ.push_back(e);
      end
   endtask

   task automatic startOp(input int kLen);
      START_in = 1'b1;
      K_LEN_in = KW'(kLen);
      startCyc = cycle;
      tick();
      START_in = 1'b0;
   endtask

   task automatic applyStimulus(input int kLen, input bit bubbles);
      int fed;
      bit slot;
      fed  = 0;
      slot = 1'b1;
      startOp(kLen);
      while (fed < kLen) begin
         OPND_VALID_in = slot;
         for (int r = 0; r < ROWS; r++) OPND1_DATA_in[r*OB +: OB] = OB'(opA[fed][r]);
         for (int c = 0; c < COLS; c++) OPND2_DATA_in[c*OB +: OB] = OB'(opB[fed][c]);
         checkOutput("opnd_ready", OPND_READY_out, 1);
         if (slot) fed++;
         tick();
         if (bubbles) slot = !slot;
      end
      OPND_VALID_in = 1'b0;
   endtask

   task automatic waitValid(input int expLat);
      for (int i = 0; i < 300; i++) begin
         if (OUT_VALID_out) break;
         tick();
      end
      checkOutput("first_valid_latency", cycle - startCyc, expLat);
   endtask

   task automatic waitDone();
      for (int i = 0; i < 300; i++) begin
         tick();
         if (DONE_out) break;
      end
      checkOutput("done_reached", DONE_out, 1);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_out_valid"}, OUT_VALID_out, 0);
      checkOutput({tag, "_opnd_ready"}, OPND_READY_out, 0);
      checkOutput({tag, "_busy"}, BUSY_out, 0);
      checkOutput({tag, "_done"}, DONE_out, 0);
      checkOutput({tag, "_out_data"}, OUT_DATA_out, 0);
      checkOutput({tag, "_out_row"}, OUT_ROW_out, 0);
   endtask

   // Monitor: compares every presented row against the queue head and the DONE pulse timing.
   initial begin
      forever begin
         @(negedge CLK);
         if (doneChk == 2) begin
            checkOutput("done_clear", DONE_out, 0);
            doneChk = 0;
         end else if (doneChk == 1) begin
            checkOutput("done_pulse", DONE_out, 1);
            if (!STALL) doneChk = 2;
         end else begin
            checkOutput("done_idle", DONE_out, 0);
         end
         if (OUT_VALID_out) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_row: got row %0d valid, expected no output", OUT_ROW_out);
            end else begin
               checkOutput("out_data", OUT_DATA_out, expQ[0].data);
               checkOutput("out_row", OUT_ROW_out, expQ[0].row);
               if (OUT_READY_in && !STALL) begin
                  if (expQ[0].last) doneChk = 1;
                  void'(expQ.pop_front());
               end
            end
         end
      end
   end

   // Watchdog so a hung handshake still ends with a summary.
   initial begin
      #300000;
      errors++;
      $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      expRow_t e;
      RSTn = 1'b0; STALL = 1'b0; START_in = 1'b0; K_LEN_in = '0;
      OPND_VALID_in = 1'b0; OPND1_DATA_in = '0; OPND2_DATA_in = '0; OUT_READY_in = 1'b1;
      repeat (3) tick();
      checkIdleOutputs("reset");
      RSTn = 1'b1;
      tick();

      $display("[TB] identity: A=I, B[k][c]=4k+c, K=4");
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) opA[k][r] = (r == k) ? 1 : 0;
         for (int c = 0; c < COLS; c++) opB[k][c] = 4 * k + c;
      end
      for (int r = 0; r < ROWS; r++) begin
         e.row = r; e.last = (r == ROWS - 1);
         for (int c = 0; c < COLS; c++) e.data[c*AB +: AB] = 4 * r + c;
         expQ.push_back(e);
      end
      applyStimulus(4, 1'b0);
      checkOutput("busy_feed_done", BUSY_out, 1);
      waitValid(12);
      waitDone();

      $display("[TB] signed: A=-128, B=-128, K=4");
      tick();
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) opA[k][r] = -128;
         for (int c = 0; c < COLS; c++) opB[k][c] = -128;
      end
      pushConst(65536);
      applyStimulus(4, 1'b0);
      waitValid(12);
      waitDone();

      $display("[TB] signed: A=127, B=-128, K=4, started in DONE cycle");
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) opA[k][r] = 127;
      end
      pushConst(-65024);
      applyStimulus(4, 1'b0);
      waitValid(12);
      waitDone();

      $display("[TB] bubbles: VALID 1,0,1,0,1 K=3");
      tick();
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < ROWS; r++) opA[k][r] = r - k + 1;
         for (int c = 0; c < COLS; c++) opB[k][c] = c + 2 * k - 3;
      end
      pushModel(3);
      applyStimulus(3, 1'b1);
      waitDone();

      $display("[TB] backpressure: READY low 5 cycles at row 2");
      tick();
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) opA[k][r] = 3 * r - k;
         for (int c = 0; c < COLS; c++) opB[k][c] = 2 * c - k + 1;
      end
      pushModel(4);
      applyStimulus(4, 1'b0);
      waitValid(12);
      for (int i = 0; i < 50; i++) begin
         if (OUT_VALID_out && OUT_ROW_out == 2'd2) break;
         tick();
      end
      checkOutput("reach_row2", OUT_ROW_out, 2);
      OUT_READY_in = 1'b0;
      repeat (5) tick();
      OUT_READY_in = 1'b1;
      waitDone();

      $display("[TB] stall 3 cycles in SKEW plus START while busy");
      tick();
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) opA[k][r] = (r + k) % 3 - 1;
         for (int c = 0; c < COLS; c++) opB[k][c] = c * k - 2;
      end
      pushModel(4);
      applyStimulus(4, 1'b0);
      START_in = 1'b1;
      K_LEN_in = 16'd2;
      tick();
      START_in = 1'b0;
      STALL = 1'b1;
      repeat (3) tick();
      STALL = 1'b0;
      waitValid(15);
      waitDone();
      repeat (3) tick();
      checkOutput("ignored_start_busy", BUSY_out, 0);
      checkOutput("ignored_start_valid", OUT_VALID_out, 0);

      $display("[TB] reset mid-FEED, then K_LEN=0");
      startOp(4);
      OPND_VALID_in = 1'b1;
      repeat (2) tick();
      RSTn = 1'b0;
      OPND_VALID_in = 1'b0;
      #2;
      checkIdleOutputs("midreset");
      repeat (2) tick();
      RSTn = 1'b1;
      tick();
      pushConst(0);
      startOp(0);
      waitValid(1);
      waitDone();
      repeat (3) tick();

      checkOutput("queue_empty", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
